// File: rtl/jam_pkg.sv
// jam_pkg: shared widths, error sentinel, scheduler state encoding and permutation check.
package jam_pkg;
  localparam int JAM_N = 8;
  localparam int W_W = 3;
  localparam int COST_W = 7;
  localparam int SUM_W = 10;
  localparam logic [SUM_W-1:0] SUM_ERR = 10'h3FF;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  function automatic logic perm_valid(input logic [JAM_N*W_W-1:0] p);
    logic [JAM_N-1:0] m;
    m = '0;
    for (int k = 0; k < JAM_N; k++) m[p[W_W*k+:W_W]] = 1'b1;
    return &m;
  endfunction
endpackage

// File: rtl/jam_rr_arbiter.sv
// jam_rr_arbiter: combinational round-robin pick, priority ascending from last_g+1.
module jam_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int GW = NREQ > 1 ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last_g,
  output logic [GW-1:0]   win,
  output logic            any
);
  // Scan from lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last_g) + k) % NREQ]) begin
        win = GW'((int'(last_g) + k) % NREQ);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/jam_cost_sched.sv
// jam_cost_sched: round-robin share of the cost-table port; checks a job permutation,
// sums its 8 costs and returns the total per requester.
module jam_cost_sched
  import jam_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*24-1:0]    perm,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       done,
  output logic [SUM_W-1:0]      sum,
  output logic                  err,
  output logic                  busy,
  output logic                  RD,
  output logic [W_W-1:0]        W,
  output logic [W_W-1:0]        J,
  input  logic [COST_W-1:0]     Cost
);
  localparam int GW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_e state_q, state_d;
  logic [GW-1:0] win, g_q, g_d, last_g_q, last_g_d;
  logic any;
  logic [23:0] perm_q, perm_d, sel_perm;
  logic [W_W-1:0] w_q, w_d, j_q, j_d;
  logic [SUM_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic err_q, err_d;
  jam_rr_arbiter #(.NREQ(NREQ), .GW(GW)) u_arb (
    .req(req), .last_g(last_g_q), .win(win), .any(any)
  );
  assign sel_perm = perm[24*int'(win)+:24];
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      g_q <= '0;
      last_g_q <= GW'(NREQ - 1);
      perm_q <= '0;
      w_q <= '0;
      j_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q <= g_d;
      last_g_q <= last_g_d;
      perm_q <= perm_d;
      w_q <= w_d;
      j_q <= j_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      err_q <= err_d;
    end
  end
  // w_q doubles as the read index; it stops at 7 so W/J hold once reads end.
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    last_g_d = last_g_q;
    perm_d = perm_q;
    w_d = w_q;
    j_d = j_q;
    acc_d = acc_q;
    sum_d = sum_q;
    err_d = err_q;
    ack = '0;
    done = '0;
    case (state_q)
      IDLE: if (any) begin
        ack[win] = 1'b1;
        g_d = win;
        perm_d = sel_perm;
        if (perm_valid(sel_perm)) begin
          state_d = ISSUE;
          w_d = '0;
          j_d = sel_perm[2:0];
          acc_d = '0;
        end else begin
          state_d = RESP;
          sum_d = SUM_ERR;
          err_d = 1'b1;
        end
      end
      ISSUE: begin
        acc_d = acc_q + SUM_W'(Cost);
        if (w_q == W_W'(JAM_N - 1)) begin
          state_d = RESP;
          sum_d = acc_d;
          err_d = 1'b0;
        end else begin
          w_d = w_q + 3'd1;
          j_d = perm_q[3*(int'(w_q)+1)+:3];
        end
      end
      RESP: begin
        done[g_q] = 1'b1;
        last_g_d = g_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = (state_q != IDLE) || any;
  assign RD = state_q == ISSUE;
  assign W = w_q;
  assign J = j_q;
  assign sum = sum_q;
  assign err = err_q;
endmodule

// File: tb/tb_jam_cost_sched.sv
// tb_jam_cost_sched: directed jobs against a behavioural cost table with hand-computed sums.
module tb_jam_cost_sched;
  logic CLK = 1'b0, RST = 1'b1;
  logic [1:0] req = '0;
  logic [47:0] perm = '0;
  logic [1:0] ack, done;
  logic [9:0] sum;
  logic err, busy, RD;
  logic [2:0] W, J;
  logic [6:0] Cost;
  int mode = 0;
  int n_chk = 0, n_err = 0;
  int gap;
  logic [23:0] id_p, rot1_p, rev_p, inv_p;

  jam_cost_sched #(.NREQ(2)) dut (
    .CLK(CLK), .RST(RST), .req(req), .perm(perm), .ack(ack), .done(done),
    .sum(sum), .err(err), .busy(busy), .RD(RD), .W(W), .J(J), .Cost(Cost)
  );

  always #5 CLK = ~CLK;
  always_comb Cost = mode == 1 ? 7'd127 : mode == 2 ? 7'(W * J) : 7'(W + J);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [23:0] mk(input int r, input bit rev);
    logic [23:0] p;
    for (int k = 0; k < 8; k++) p[3*k+:3] = rev ? 3'(7 - k) : 3'((k + r) % 8);
    return p;
  endfunction

  task automatic zero_outs(input string tag);
    chk({tag, "_ack"}, ack, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rd"}, RD, 0);
    chk({tag, "_w"}, W, 0);
    chk({tag, "_j"}, J, 0);
  endtask

  task automatic do_job(input int r, input logic [23:0] p, input logic [9:0] es,
                        input logic ee, input bit drop, output int n);
    perm[24*r+:24] = p;
    req[r] = 1'b1;
    #1;
    n = 0;
    while (ack == 0 && n < 40) begin
      tick();
      n++;
    end
    chk("ack", ack, 1 << r);
    chk("busy_ack", busy, 1);
    tick();
    if (!ee) begin
      for (int k = 0; k < 8; k++) begin
        chk("rd", RD, 1);
        chk("w", W, k);
        chk("j", J, p[3*k+:3]);
        tick();
      end
    end else chk("rd_err", RD, 0);
    chk("done", done, 1 << r);
    chk("sum", sum, es);
    chk("err", err, ee);
    chk("busy_done", busy, 1);
    if (drop) req = '0;
    tick();
  endtask

  initial begin
    id_p = mk(0, 0);
    rot1_p = mk(1, 0);
    rev_p = mk(0, 1);
    inv_p = {3'd6, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    repeat (2) tick();
    zero_outs("rst");
    RST = 1'b0;
    tick();
    do_job(0, id_p, 10'd56, 1'b0, 1'b1, gap);
    chk("idle_busy", busy, 0);
    do_job(1, inv_p, 10'h3FF, 1'b1, 1'b1, gap);
    chk("inv_no_rd", RD, 0);
    mode = 1;
    do_job(0, rot1_p, 10'd1016, 1'b0, 1'b1, gap);
    // contention from a fresh reset: both held, grants must alternate 0,1,0,1
    RST = 1'b1;
    tick();
    mode = 2;
    perm = {rot1_p, id_p};
    req = 2'b11;
    tick();
    RST = 1'b0;
    do_job(0, id_p, 10'd140, 1'b0, 1'b0, gap);
    do_job(1, rot1_p, 10'd112, 1'b0, 1'b0, gap);
    chk("alt_gap1", gap, 0);
    do_job(0, id_p, 10'd140, 1'b0, 1'b0, gap);
    chk("alt_gap2", gap, 0);
    do_job(1, rot1_p, 10'd112, 1'b0, 1'b1, gap);
    chk("alt_gap3", gap, 0);
    // reset in the middle of a job
    mode = 0;
    perm[23:0] = id_p;
    req[0] = 1'b1;
    #1;
    chk("mid_ack", ack, 1);
    repeat (5) tick();
    chk("mid_w4", W, 4);
    chk("mid_rd", RD, 1);
    RST = 1'b1;
    req = '0;
    #1;
    zero_outs("mid");
    repeat (2) begin
      tick();
      chk("mid_nodone", done, 0);
    end
    RST = 1'b0;
    tick();
    do_job(0, id_p, 10'd56, 1'b0, 1'b1, gap);
    // back-to-back on a single held requester
    mode = 2;
    do_job(0, id_p, 10'd140, 1'b0, 1'b0, gap);
    do_job(0, rot1_p, 10'd112, 1'b0, 1'b0, gap);
    chk("b2b_gap1", gap, 0);
    do_job(0, rev_p, 10'd56, 1'b0, 1'b1, gap);
    chk("b2b_gap2", gap, 0);
    chk("end_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/jam_cost_sched.md
# jam_cost_sched

Round-robin scheduler that shares the single combinational cost-table port (W, J -> Cost) among NREQ search engines. Each engine submits a complete 8-worker job permutation; the scheduler checks it, reads all 8 costs, accumulates the total and returns it with a done pulse. It sits between the permutation engines and the external cost table, and is the only driver of W/J.

## Interface
- NREQ, 2, number of requesters (legal 1..4)
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- req  in  NREQ  per-requester request, level; must stay high with perm stable until ack
- perm  in  NREQ*24  per-requester permutation; requester i uses slice [24i+23:24i]; field k = bits [3k+2:3k] = job for worker k
- ack  out  NREQ  one-cycle pulse: request accepted, perm latched
- done  out  NREQ  one-cycle pulse: result on sum/err valid for that requester
- sum  out  10  total cost of the job; held until next done
- err  out  1  qualifies done: perm was not a permutation
- busy  out  1  high from ack cycle through done cycle
- RD  out  1  table read active; W/J valid only when high
- W  out  3  worker index to cost table
- J  out  3  job index to cost table
- Cost  in  7  table data, combinational from W/J, sampled at the same clock edge

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE: if no req is high, stay. Otherwise the round-robin arbiter picks winner g; ack[g]=1 this cycle (combinational); at the edge latch perm slice, g, and check result.
  - Check: perm is valid iff its 8 fields are pairwise distinct. Valid -> ISSUE with idx=0, acc=0. Invalid -> RESP with err latched 1.
- ISSUE: RD=1, W=idx, J=perm_q[idx] (driven from registers). Each edge: acc += Cost (zero-extended to 10 bits), idx++. At idx==7 the final add is performed and state -> RESP.
- RESP: done[g]=1, sum=acc (or 10'h3FF when err), err valid; rr pointer moves to g; -> IDLE.
- Round-robin: priority starts at (last_g+1) mod NREQ and ascends. After reset, last_g=NREQ-1, so requester 0 has highest priority.
- Arithmetic: max total 8*127=1016 < 1023, so no overflow. 10'h3FF is reserved as the error sentinel.
- req from non-granted requesters is ignored while busy. They are arbitrated in the next IDLE cycle.
- A requester holding req through its own done is re-granted only if no other requester is high.

## Timing
- Reset values: ack=0, done=0, sum=0, err=0, busy=0, RD=0, W=0, J=0, state=IDLE, last_g=NREQ-1.
- Reset mid-job abandons the job; no done is issued.
- Valid job: ack in cycle T, ISSUE cycles T+1..T+8, done in cycle T+9, next ack no earlier than T+10. Throughput is 1 job per 10 cycles.
- Invalid job: ack in cycle T, done with err=1 in cycle T+1, no RD cycles.
- W/J change only at clock edges. When RD=0, W/J hold their last value.
- sum/err update at the edge entering RESP and hold until the next RESP.

## Structure
- jam_pkg holds:
  - JAM_N=8, W_W=3, COST_W=7, SUM_W=10
  - SUM_ERR=10'h3FF
  - state enum {IDLE, ISSUE, RESP}
  - function perm_valid(24-bit), a 0..7 one-hot coverage check
- Sub-module jam_rr_arbiter (parameter NREQ): inputs req and last_g, outputs winner index and any-valid flag; purely combinational. The last_g register lives in the parent.

## Test plan
- Single job, req0, perm 0..7 identity, Cost(w,j)=w+j -> ack T, RD for 8 cycles with W=J=0..7, done[0] at T+9, sum=56, err=0.
- Contention: req0 and req1 both high from reset -> requester 0 granted first, requester 1 at the next IDLE. Both held high -> grants alternate 0,1,0,1.
- Invalid perm on req1 (fields 0,1,2,3,4,5,6,6) -> ack, done[1] one cycle later, err=1, sum=10'h3FF, RD never asserted.
- Max cost: all Cost=127 -> sum=1016, no wrap.
- RST asserted at ISSUE idx=4 -> all outputs zero immediately, no done. Next req0 after release is served normally.
- Back-to-back: req0 held high alone for 3 jobs -> acks spaced exactly 10 cycles apart, each sum correct.
